// File: rtl/nq_integration1.sv
// NanoQuarter stage 1: fetch, decode, register file read with stage-2 forwarding,
// and the stage-1/stage-2 pipeline register. Also owns the PC and the writeback port.
module nq_integration1 #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'h2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic [15:0] s2_result,
    input  logic        s2_regwrite,
    input  logic [31:0] s2_pc_next,
    output logic [15:0] reg1data_out,
    output logic [15:0] reg2data_out,
    output logic [7:0]  jtarget_out,
    output logic [7:0]  idata_out,
    output logic [5:0]  memaddr_out,
    output logic [4:0]  boffset_out,
    output logic [2:0]  funct_out,
    output logic [1:0]  op_out,
    output logic [1:0]  shamt_out,
    output logic        bne_out,
    output logic        jr_out,
    output logic        jmp_out,
    output logic        memread_out,
    output logic        memwrite_out,
    output logic [31:0] PC_out
);

    typedef struct packed {
        logic [15:0] reg1;
        logic [15:0] reg2;
        logic [7:0]  imm;
        logic [5:0]  memaddr;
        logic [4:0]  boffset;
        logic [2:0]  funct;
        logic [1:0]  op;
        logic [1:0]  shamt;
        logic        bne;
        logic        jr;
        logic        jmp;
        logic        memread;
        logic        memwrite;
    } s1s2_t;

    localparam s1s2_t BUBBLE = '{op: 2'b11, default: '0};

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    s1s2_t       pipe_q, pipe_d;
    logic        ex_valid_q, ex_valid_d;
    logic [2:0]  ex_rd_q, ex_rd_d;
    logic [15:0] rf_q [8];

    logic [15:0] instr;
    logic [2:0]  rs_idx, rt_idx;
    logic [15:0] rd1, rd2;
    logic        wr_en;
    logic        redirect;
    s1s2_t       dec;
    logic [2:0]  dec_rd;

    assign instr  = imem_rdata;
    assign rs_idx = instr[13:11];
    assign rt_idx = instr[10:8];

    // Fetch port is valid-only: imem_valid qualifies imem_rdata for imem_addr in the
    // same cycle, there is no backpressure, and a redirect discards the word.
    assign imem_addr = pc_q;
    assign imem_req  = rst;

    assign wr_en    = ex_valid_q && s2_regwrite && (ex_rd_q != 3'd0);
    assign redirect = ex_valid_q && (s2_pc_next != pc_out_q + PC_STEP);

    // Operand read with bypass of the result being written back this same cycle.
    always_comb begin
        rd1 = rf_q[rs_idx];
        rd2 = rf_q[rt_idx];
        if (rs_idx == 3'd0) begin
            rd1 = 16'h0;
        end else if (wr_en && (rs_idx == ex_rd_q)) begin
            rd1 = s2_result;
        end
        if (rt_idx == 3'd0) begin
            rd2 = 16'h0;
        end else if (wr_en && (rt_idx == ex_rd_q)) begin
            rd2 = s2_result;
        end
    end

    always_comb begin
        dec         = '0;
        dec_rd      = 3'd0;
        dec.op      = instr[15:14];
        dec.imm     = instr[7:0];
        dec.memaddr = instr[5:0];
        dec.boffset = instr[4:0];
        case (instr[15:14])
            2'b00: begin
                dec.reg1  = rd1;
                dec.reg2  = rd2;
                dec.shamt = instr[4:3];
                dec.funct = instr[2:0];
                dec_rd    = instr[7:5];
            end
            2'b01: begin
                dec.reg1  = rd1;
                dec.funct = instr[10:8];
                case (instr[10:8])
                    3'b000: dec_rd = instr[13:11];
                    3'b001: begin
                        dec.memread = 1'b1;
                        dec_rd      = instr[13:11];
                    end
                    3'b010: dec.jmp = 1'b1;
                    3'b011: begin
                        dec.jmp = 1'b1;
                        dec.jr  = 1'b1;
                    end
                    3'b100: dec.memwrite = 1'b1;
                    default: ;
                endcase
            end
            2'b10: begin
                dec.reg1 = rd1;
                dec.reg2 = rd2;
                dec.bne  = (rd1 != rd2);
            end
            default: ;
        endcase
    end

    // Redirect beats a valid fetch; a stall or a squash loads a bubble.
    always_comb begin
        pipe_d     = BUBBLE;
        ex_valid_d = 1'b0;
        ex_rd_d    = 3'd0;
        pc_d       = pc_q;
        pc_out_d   = pc_out_q;
        if (redirect) begin
            pc_d = s2_pc_next;
        end else if (imem_valid) begin
            pipe_d     = dec;
            ex_valid_d = 1'b1;
            ex_rd_d    = dec_rd;
            pc_out_d   = pc_q;
            pc_d       = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            pc_out_q   <= RESET_PC;
            pipe_q     <= BUBBLE;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= 3'd0;
        end else begin
            pc_q       <= pc_d;
            pc_out_q   <= pc_out_d;
            pipe_q     <= pipe_d;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0;
            end
        end else if (wr_en) begin
            rf_q[ex_rd_q] <= s2_result;
        end
    end

    assign reg1data_out = pipe_q.reg1;
    assign reg2data_out = pipe_q.reg2;
    assign jtarget_out  = pipe_q.imm;
    assign idata_out    = pipe_q.imm;
    assign memaddr_out  = pipe_q.memaddr;
    assign boffset_out  = pipe_q.boffset;
    assign funct_out    = pipe_q.funct;
    assign op_out       = pipe_q.op;
    assign shamt_out    = pipe_q.shamt;
    assign bne_out      = pipe_q.bne;
    assign jr_out       = pipe_q.jr;
    assign jmp_out      = pipe_q.jmp;
    assign memread_out  = pipe_q.memread;
    assign memwrite_out = pipe_q.memwrite;
    assign PC_out       = pc_out_q;

endmodule

// File: tb/tb_nq_integration1.sv
// Bench for nq_integration1: directed scenarios then random traffic, each cycle
// compared against an architectural model of the register file, PC and stage-2 slot.
module tb_nq_integration1;

    localparam logic [31:0] STEP = 32'h2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic [15:0] s2_result = 16'h0;
    logic        s2_regwrite = 1'b0;
    logic [31:0] s2_pc_next = 32'h0;
    logic [15:0] reg1data_out, reg2data_out;
    logic [7:0]  jtarget_out, idata_out;
    logic [5:0]  memaddr_out;
    logic [4:0]  boffset_out;
    logic [2:0]  funct_out;
    logic [1:0]  op_out, shamt_out;
    logic        bne_out, jr_out, jmp_out, memread_out, memwrite_out;
    logic [31:0] PC_out;

    nq_integration1 dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .s2_result(s2_result), .s2_regwrite(s2_regwrite), .s2_pc_next(s2_pc_next),
        .reg1data_out(reg1data_out), .reg2data_out(reg2data_out),
        .jtarget_out(jtarget_out), .idata_out(idata_out),
        .memaddr_out(memaddr_out), .boffset_out(boffset_out),
        .funct_out(funct_out), .op_out(op_out), .shamt_out(shamt_out),
        .bne_out(bne_out), .jr_out(jr_out), .jmp_out(jmp_out),
        .memread_out(memread_out), .memwrite_out(memwrite_out),
        .PC_out(PC_out)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic [15:0] r1;
        logic [15:0] r2;
        logic [7:0]  imm;
        logic [5:0]  maddr;
        logic [4:0]  boff;
        logic [2:0]  funct;
        logic [1:0]  op;
        logic [1:0]  shamt;
        logic        bne;
        logic        jr;
        logic        jmp;
        logic        mrd;
        logic        mwr;
    } exp_t;

    localparam exp_t BUB = '{op: 2'b11, default: '0};

    // op 01 function table: {writes rd, memread, memwrite, jmp, jr}
    logic [4:0] op01_flags [8] = '{5'b10000, 5'b11000, 5'b00010, 5'b00011,
                                   5'b00100, 5'b00000, 5'b00000, 5'b00000};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] m_rf [8];
    logic [31:0] m_pc, m_pc_out;
    logic        m_ex_valid;
    logic [2:0]  m_ex_rd;
    logic        m_req;
    exp_t        m_exp;
    logic        f_wr;
    logic [2:0]  f_idx;
    logic [15:0] f_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] mread(input logic [2:0] idx);
        if (idx == 3'd0) return 16'h0;
        if (f_wr && idx == f_idx) return f_res;
        return m_rf[idx];
    endfunction

    function automatic void decode(input logic [15:0] ins, output exp_t e, output logic [2:0] dest);
        logic [15:0] a, b;
        logic [4:0]  fl;
        logic        wflag;
        a       = mread(ins[13:11]);
        b       = mread(ins[10:8]);
        e       = '0;
        dest    = 3'd0;
        e.op    = ins[15:14];
        e.imm   = ins[7:0];
        e.maddr = ins[5:0];
        e.boff  = ins[4:0];
        if (ins[15:14] == 2'b00) begin
            e.r1 = a; e.r2 = b; e.shamt = ins[4:3]; e.funct = ins[2:0]; dest = ins[7:5];
        end else if (ins[15:14] == 2'b01) begin
            fl = op01_flags[ins[10:8]];
            {wflag, e.mrd, e.mwr, e.jmp, e.jr} = fl;
            e.r1 = a; e.funct = ins[10:8];
            dest = wflag ? ins[13:11] : 3'd0;
        end else if (ins[15:14] == 2'b10) begin
            e.r1 = a; e.r2 = b; e.bne = (a != b);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_pc = 32'h0; m_pc_out = 32'h0;
        m_ex_valid = 1'b0; m_ex_rd = 3'd0;
        m_exp = BUB; m_req = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic [15:0] ins, input logic [15:0] res,
                                       input logic rw, input logic [31:0] pcn);
        exp_t       e;
        logic [2:0] dest;
        logic       redir;
        f_wr  = m_ex_valid && rw && (m_ex_rd != 3'd0);
        f_idx = m_ex_rd;
        f_res = res;
        redir = m_ex_valid && (pcn != m_pc_out + STEP);
        e     = BUB;
        dest  = 3'd0;
        if (redir) begin
            m_pc = pcn;
        end else if (v) begin
            decode(ins, e, dest);
            m_pc_out = m_pc;
            m_pc     = m_pc + STEP;
        end
        m_exp      = e;
        m_ex_valid = !redir && v;
        m_ex_rd    = dest;
        if (f_wr) m_rf[f_idx] = res;
    endfunction

    task automatic compare_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_req", 32'(imem_req), 32'(m_req));
        chk("PC_out", PC_out, m_pc_out);
        chk("op_out", 32'(op_out), 32'(m_exp.op));
        chk("funct_out", 32'(funct_out), 32'(m_exp.funct));
        chk("shamt_out", 32'(shamt_out), 32'(m_exp.shamt));
        chk("reg1data_out", 32'(reg1data_out), 32'(m_exp.r1));
        chk("reg2data_out", 32'(reg2data_out), 32'(m_exp.r2));
        chk("jtarget_out", 32'(jtarget_out), 32'(m_exp.imm));
        chk("idata_out", 32'(idata_out), 32'(m_exp.imm));
        chk("memaddr_out", 32'(memaddr_out), 32'(m_exp.maddr));
        chk("boffset_out", 32'(boffset_out), 32'(m_exp.boff));
        chk("bne_out", 32'(bne_out), 32'(m_exp.bne));
        chk("jr_out", 32'(jr_out), 32'(m_exp.jr));
        chk("jmp_out", 32'(jmp_out), 32'(m_exp.jmp));
        chk("memread_out", 32'(memread_out), 32'(m_exp.mrd));
        chk("memwrite_out", 32'(memwrite_out), 32'(m_exp.mwr));
    endtask

    task automatic cycle(input logic v, input logic [15:0] ins, input logic [15:0] res,
                         input logic rw, input logic redir, input logic [31:0] tgt);
        @(negedge clk);
        imem_valid  = v;
        imem_rdata  = ins;
        s2_result   = res;
        s2_regwrite = rw;
        s2_pc_next  = redir ? tgt : m_pc_out + STEP;
        model_step(v, ins, res, rw, s2_pc_next);
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic apply_reset();
        imem_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        m_req = 1'b1;
    endtask

    function automatic logic [15:0] rtype(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] rd, input logic [1:0] sh,
                                          input logic [2:0] fn);
        return {2'b00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [15:0] itype(input logic [2:0] rd, input logic [2:0] fn,
                                          input logic [7:0] imm);
        return {2'b01, rd, fn, imm};
    endfunction

    function automatic logic [15:0] bnei(input logic [2:0] ra, input logic [2:0] rb,
                                         input logic [4:0] off);
        return {2'b10, ra, rb, 3'b000, off};
    endfunction

    initial begin
        logic        rv, rrw, rredir;
        logic [15:0] rins, rres;
        logic [31:0] rtgt;

        #1;
        apply_reset();

        // forwarding into rs, then the written value read back from the file
        cycle(1, rtype(0, 0, 2, 0, 0), 16'h0000, 0, 0, 0);
        cycle(1, rtype(2, 0, 0, 0, 0), 16'h1234, 1, 0, 0);
        chk("fwd_reg1", 32'(reg1data_out), 32'h1234);
        cycle(1, rtype(2, 0, 0, 0, 0), 16'hDEAD, 1, 0, 0);
        chk("rf2_written", 32'(reg1data_out), 32'h1234);

        // BNE: equal, then different operands, both via forwarding
        cycle(1, rtype(0, 0, 1, 0, 0), 16'h0000, 0, 0, 0);
        cycle(1, rtype(0, 0, 2, 0, 0), 16'h0005, 1, 0, 0);
        cycle(1, bnei(1, 2, 5'h15), 16'h0005, 1, 0, 0);
        chk("bne_equal", 32'(bne_out), 32'h0);
        cycle(1, rtype(0, 0, 2, 0, 0), 16'h0000, 0, 0, 0);
        cycle(1, bnei(1, 2, 5'h0A), 16'h0006, 1, 0, 0);
        chk("bne_differ", 32'(bne_out), 32'h1);
        chk("bne_boffset", 32'(boffset_out), 32'h0A);

        // taken branch, then the PC_out=0x10 / s2_pc_next=0x40 redirect
        cycle(1, rtype(1, 1, 1, 1, 1), 16'h0000, 0, 1, 32'h100);
        chk("taken_bubble", 32'(op_out), 32'h3);
        chk("taken_target", imem_addr, 32'h100);
        cycle(1, itype(4, 3'b000, 8'h5A), 16'h0000, 0, 0, 0);
        cycle(1, rtype(7, 7, 7, 3, 7), 16'h0000, 0, 1, 32'h10);
        cycle(1, rtype(0, 0, 0, 0, 0), 16'h0000, 0, 0, 0);
        chk("pc_out_10", PC_out, 32'h10);
        chk("imem_addr_12", imem_addr, 32'h12);
        cycle(1, rtype(7, 7, 7, 3, 7), 16'h0000, 0, 1, 32'h40);
        chk("redir_bubble", 32'(op_out), 32'h3);
        chk("redir_addr", imem_addr, 32'h40);
        cycle(1, rtype(0, 0, 5, 0, 0), 16'h0000, 0, 0, 0);
        chk("pc_out_40", PC_out, 32'h40);

        // three stall cycles; bubbles with s2_regwrite high must not write r5
        cycle(0, 16'hFFFF, 16'h0000, 0, 0, 0);
        cycle(0, 16'hFFFF, 16'hBEEF, 1, 0, 0);
        cycle(0, 16'hFFFF, 16'hBEEF, 1, 0, 0);
        chk("stall_addr", imem_addr, 32'h42);
        chk("stall_bubble", 32'(op_out), 32'h3);
        cycle(1, rtype(5, 0, 0, 0, 0), 16'hBEEF, 1, 0, 0);
        chk("r5_untouched", 32'(reg1data_out), 32'h0);

        // r0 is neither written nor forwarded
        cycle(1, rtype(0, 0, 0, 0, 0), 16'h0000, 0, 0, 0);
        cycle(1, rtype(0, 0, 0, 0, 0), 16'hFFFF, 1, 0, 0);
        chk("r0_no_fwd", 32'(reg1data_out), 32'h0);
        cycle(1, itype(0, 3'b001, 8'h00), 16'hFFFF, 1, 0, 0);
        cycle(1, rtype(0, 0, 0, 0, 0), 16'hFFFF, 1, 0, 0);
        chk("r0_read", 32'(reg2data_out), 32'h0);

        // PC wraps modulo 2^32
        cycle(1, 16'hC000, 16'h0000, 0, 1, 32'hFFFF_FFFE);
        cycle(1, 16'hC000, 16'h0000, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc_out", PC_out, 32'hFFFF_FFFE);

        // reset mid-stream discards rf[3] and the pending writeback
        cycle(1, rtype(0, 0, 3, 0, 0), 16'h0000, 0, 0, 0);
        cycle(1, rtype(0, 0, 3, 0, 0), 16'h00AA, 1, 0, 0);
        cycle(1, rtype(3, 0, 3, 0, 0), 16'h0000, 0, 0, 0);
        chk("r3_loaded", 32'(reg1data_out), 32'h00AA);
        #2;
        s2_result   = 16'h5555;
        s2_regwrite = 1'b1;
        apply_reset();
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_op", 32'(op_out), 32'h3);
        cycle(1, rtype(3, 0, 0, 0, 0), 16'h5555, 1, 0, 0);
        chk("r3_after_reset", 32'(reg1data_out), 32'h0);

        for (int i = 0; i < 400; i++) begin
            rv     = ($urandom_range(0, 9) != 0);
            rins   = 16'($urandom);
            rres   = 16'($urandom);
            rrw    = 1'($urandom_range(0, 1));
            rredir = ($urandom_range(0, 7) == 0);
            rtgt   = $urandom & 32'hFFFF_FFFE;
            cycle(rv, rins, rres, rrw, rredir, rtgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nq_integration1.md
# nq_integration1

Stage 1 of the NanoQuarter integration pipeline: fetch and decode, with the architectural register file. Each cycle it:
- fetches a 16-bit instruction at the current PC;
- decodes its fields and reads the operands, forwarding from stage 2;
- resolves the branch condition;
- registers everything into the stage-1/stage-2 pipeline register.

Stage 2 is combinational and consumes these registered outputs. This block also:
- writes stage 2's result back into the register file;
- owns the PC, redirecting fetch and squashing the decoded instruction whenever stage 2's next-PC disagrees with the sequential fetch.

## Interface
Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- PC_STEP, 32'h2, sequential PC increment.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  32  fetch address; equals the PC register.
- imem_req  out  1  fetch request; 0 during reset, 1 otherwise.
- imem_valid  in  1  imem_rdata holds the instruction at imem_addr this cycle.
- imem_rdata  in  16  instruction word.
- s2_result  in  16  stage-2 result (data from either memory or the ALU).
- s2_regwrite  in  1  stage-2 register-write flag.
- s2_pc_next  in  32  stage-2 next PC.
- reg1data_out, reg2data_out  out  16  operand values.
- jtarget_out, idata_out  out  8  each equals instr[7:0].
- memaddr_out  out  6  equals instr[5:0].
- boffset_out  out  5  equals instr[4:0].
- funct_out  out  3  function code.
- op_out  out  2  operation type.
- shamt_out  out  2  shift amount.
- bne_out, jr_out, jmp_out, memread_out, memwrite_out  out  1 each  control flags.
- PC_out  out  32  PC of the instruction in stage 2.

## Operation
Decode; instr = imem_rdata, op = instr[15:14].
- op 00, R-type:
  - rs = [13:11], rt = [10:8], rd = [7:5], shamt = [4:3], funct = [2:0].
  - reg1 = rs, reg2 = rt; writes rd.
- op 01, I/J/mem type:
  - rd = [13:11], funct = [10:8].
  - reg1 = rd; reg2 is forced to 0.
  - funct 000 = immediate op, writes rd.
  - funct 001 = LW: memread = 1, writes rd.
  - funct 010 = J: jmp = 1.
  - funct 011 = JR: jmp = 1, jr = 1.
  - funct 100 = SW: memwrite = 1.
  - funct 101–111: all control flags 0.
- op 10, BNE:
  - reg1 = [13:11], reg2 = [10:8].
  - bne = (forwarded reg1 != forwarded reg2).
  - funct and shamt are 0.
- op 11, NOP: every control flag 0.
- Any field not defined above for the decoded op drives 0.

Register file:
- 8 × 16 bits; r0 reads as 0 and is never written.
- Reads are combinational.

Writeback and forwarding:
- Internal state: ex_valid and ex_rd (the destination of the instruction in stage 2). ex_rd is 0 for instructions with no destination.
- Write condition: ex_valid && s2_regwrite && ex_rd != 0. When true, rf[ex_rd] <= s2_result at the rising edge.
- Same-cycle forwarding: when the write condition is true and a decoded read index equals ex_rd, the operand and the bne compare both use s2_result.

Redirect, evaluated each cycle:
- redirect = ex_valid && (s2_pc_next != PC_out + PC_STEP).
- If redirect: PC <= s2_pc_next, and a bubble is loaded.
- Else if imem_valid: the decoded instruction is loaded with ex_valid = 1, PC_out <= PC, and PC <= PC + PC_STEP.
- Else (fetch stall): a bubble is loaded and PC holds.

Bubble contents: op_out = 11, all flags 0, all data and field outputs 0, ex_valid = 0, ex_rd = 0. PC_out holds its value.

PC arithmetic is 32-bit modulo 2^32; 32'hFFFFFFFE + 2 wraps to 0.

## Timing
- Reset (rst = 0, asynchronous):
  - PC = RESET_PC; PC_out = RESET_PC.
  - All register-file entries 0.
  - Bubble loaded: op_out = 11, all other outputs 0, ex_valid = 0.
  - Reset asserted mid-operation discards the in-flight instruction; the pending writeback does not occur.
- Latency: an instruction accepted in cycle N appears on the stage-2 outputs in cycle N+1. Its writeback lands at the rising edge that ends cycle N+1.
- Taken branch or jump in stage 2 in cycle N+1:
  - The instruction fetched in N+1 is squashed.
  - The target appears on imem_addr in N+2.
  - Penalty: 1 bubble.
- Priority when redirect and imem_valid are both high: redirect wins; imem_rdata is ignored.
- Back-to-back dependent instructions need no stall: forwarding covers the only in-flight writer.

## Test plan
- Reset: rst low mid-stream, with rf[3] = 0x00AA. Required: imem_addr = 0, op_out = 11, all flags 0; after release, rf[3] reads 0.
- Forwarding: stage 2 holds a write to r2 with s2_result = 0x1234 and s2_regwrite = 1; the decoded R-type reads rs = r2. Required: reg1data_out = 0x1234 next cycle and rf[2] = 0x1234.
- BNE compare: r1 = 5, r2 = 5 → bne_out = 0. Then r1 = 5, r2 = 6 → bne_out = 1, boffset_out = instr[4:0].
- Redirect: PC_out = 0x10, imem_addr = 0x12, s2_pc_next = 0x40, imem_valid = 1. Required: next cycle op_out = 11, imem_addr = 0x40; the instruction fetched at 0x40 issues the following cycle with PC_out = 0x40.
- Fetch stall: imem_valid = 0 for 3 cycles. Required: imem_addr held, three bubbles issued, no register-file writes from bubbles.
- r0 protection: a write to r0 with s2_result = 0xFFFF. Required: a later read of r0 gives 0x0000, and no forwarding occurs for index 0.
